// File: rtl/nh_lcd_pixel_feeder_pkg.sv
// Shared definitions for the LCD pixel path: pixel and FIFO word widths,
// the end-of-line bit position and the feeder state encoding.
package nh_lcd_defines;

  localparam int LCD_DATAS_WIDTH = 24;
  localparam int LCD_EOL_BIT     = LCD_DATAS_WIDTH;
  localparam int LCD_FIFO_WIDTH  = LCD_DATAS_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRAB    = 2'd1,
    ST_FILL    = 2'd2,
    ST_RELEASE = 2'd3
  } feeder_state_e;

endpackage

// File: rtl/nh_lcd_pixel_feeder.sv
// Write-side producer for the LCD ping-pong FIFO. Takes a valid/ready RGB
// stream, tags the last pixel of each line, and closes a buffer at every
// line end so end-of-line always lands on the final word of a buffer.
module nh_lcd_pixel_feeder
  import nh_lcd_defines::*;
#(
  parameter int DATAS_WIDTH = LCD_DATAS_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_enable,
  input  logic [31:0]            i_image_width,
  input  logic [31:0]            i_image_height,
  input  logic                   i_s_valid,
  output logic                   o_s_ready,
  input  logic [DATAS_WIDTH-1:0] i_s_data,
  input  logic [1:0]             i_wr_rdy,
  output logic [1:0]             o_wr_act,
  input  logic [23:0]            i_wr_size,
  output logic                   o_wr_stb,
  output logic [DATAS_WIDTH:0]   o_wr_data,
  output logic [31:0]            o_line_count,
  output logic                   o_frame_done,
  output logic                   o_cfg_err
);

  feeder_state_e state_q, state_d;
  logic [1:0]    act_q, act_d;
  logic [31:0]   count_q, count_d;
  logic [31:0]   pixel_count_q, pixel_count_d;
  logic [31:0]   line_count_q, line_count_d;
  logic          frame_done_q, frame_done_d;
  logic          cfg_err_q, cfg_err_d;

  logic [31:0]   wr_size_ext;
  logic          geom_bad;
  logic          handshake;
  logic          eol;
  logic          last_word;
  logic          last_line;

  // A zero width would make width-1 wrap, so zero geometry is refused up front.
  assign wr_size_ext = {8'd0, i_wr_size};
  assign geom_bad    = (i_image_width == 32'd0) || (i_image_height == 32'd0);
  assign o_s_ready   = (state_q == ST_FILL) && (count_q < wr_size_ext);
  assign handshake   = o_s_ready && i_s_valid;
  assign eol         = (pixel_count_q == (i_image_width - 32'd1));
  assign last_word   = ((count_q + 32'd1) >= wr_size_ext);
  assign last_line   = (line_count_q == (i_image_height - 32'd1));
  assign o_wr_stb    = handshake;

  assign o_wr_act     = act_q;
  assign o_line_count = line_count_q;
  assign o_frame_done = frame_done_q;
  assign o_cfg_err    = cfg_err_q;

  // Write word is the accepted pixel with the end-of-line flag on top; zero when idle.
  always_comb begin
    o_wr_data = '0;
    if (handshake) begin
      o_wr_data[DATAS_WIDTH-1:0] = i_s_data;
      o_wr_data[DATAS_WIDTH]     = eol;
    end
  end

  // Next-state logic: buffer grant, fill with line/frame counting, release gap.
  always_comb begin
    state_d       = state_q;
    act_d         = act_q;
    count_d       = count_q;
    pixel_count_d = pixel_count_q;
    line_count_d  = line_count_q;
    frame_done_d  = 1'b0;
    cfg_err_d     = cfg_err_q;

    case (state_q)
      ST_IDLE: begin
        cfg_err_d     = geom_bad;
        pixel_count_d = 32'd0;
        line_count_d  = 32'd0;
        if (i_enable && !geom_bad) begin
          state_d = ST_GRAB;
        end
      end

      ST_GRAB: begin
        if ((act_q == 2'b00) && (i_wr_rdy != 2'b00)) begin
          act_d   = i_wr_rdy[0] ? 2'b01 : 2'b10;
          count_d = 32'd0;
          state_d = ST_FILL;
        end
      end

      ST_FILL: begin
        if (handshake) begin
          count_d = count_q + 32'd1;
          if (eol) begin
            pixel_count_d = 32'd0;
            if (last_line) begin
              line_count_d = 32'd0;
              frame_done_d = 1'b1;
            end else begin
              line_count_d = line_count_q + 32'd1;
            end
          end else begin
            pixel_count_d = pixel_count_q + 32'd1;
          end
          if (eol || last_word) begin
            act_d   = 2'b00;
            state_d = ST_RELEASE;
          end
        end else if (count_q >= wr_size_ext) begin
          act_d   = 2'b00;
          state_d = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        if (i_enable) begin
          state_d = ST_GRAB;
        end else begin
          state_d       = ST_IDLE;
          pixel_count_d = 32'd0;
          line_count_d  = 32'd0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        act_d   = 2'b00;
      end
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      act_q         <= 2'b00;
      count_q       <= 32'd0;
      pixel_count_q <= 32'd0;
      line_count_q  <= 32'd0;
      frame_done_q  <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      act_q         <= act_d;
      count_q       <= count_d;
      pixel_count_q <= pixel_count_d;
      line_count_q  <= line_count_d;
      frame_done_q  <= frame_done_d;
      cfg_err_q     <= cfg_err_d;
    end
  end

endmodule

// File: tb/tb_nh_lcd_pixel_feeder.sv
// Self-checking bench for nh_lcd_pixel_feeder: random streams checked against
// a line/buffer chunking model, plus directed stall, reset and config cases.
module tb_nh_lcd_pixel_feeder;
  import nh_lcd_defines::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_enable;
  logic [31:0] i_image_width;
  logic [31:0] i_image_height;
  logic        i_s_valid;
  logic        o_s_ready;
  logic [23:0] i_s_data;
  logic [1:0]  i_wr_rdy;
  logic [1:0]  o_wr_act;
  logic [23:0] i_wr_size;
  logic        o_wr_stb;
  logic [24:0] o_wr_data;
  logic [31:0] o_line_count;
  logic        o_frame_done;
  logic        o_cfg_err;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    bit         eol;
    bit         last_buf;
    bit         last_frame;
    logic [1:0] act;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  nh_lcd_pixel_feeder #(.DATAS_WIDTH(LCD_DATAS_WIDTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_enable       (i_enable),
    .i_image_width  (i_image_width),
    .i_image_height (i_image_height),
    .i_s_valid      (i_s_valid),
    .o_s_ready      (o_s_ready),
    .i_s_data       (i_s_data),
    .i_wr_rdy       (i_wr_rdy),
    .o_wr_act       (o_wr_act),
    .i_wr_size      (i_wr_size),
    .o_wr_stb       (o_wr_stb),
    .o_wr_data      (o_wr_data),
    .o_line_count   (o_line_count),
    .o_frame_done   (o_frame_done),
    .o_cfg_err      (o_cfg_err)
  );

  task automatic do_reset();
    rst       = 1'b1;
    i_enable  = 1'b0;
    i_s_valid = 1'b0;
    i_s_data  = '0;
    i_wr_rdy  = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Model: each line is cut into buffers of at most size words; buffers alternate 01/10.
  task automatic build_model(input int w, input int h, input int size, input int frames);
    int   buf_idx;
    int   in_buf;
    exp_t e;
    exp_q.delete();
    buf_idx = 0;
    for (int f = 0; f < frames; f++) begin
      for (int l = 0; l < h; l++) begin
        in_buf = 0;
        for (int p = 0; p < w; p++) begin
          in_buf++;
          e.eol        = (p == w - 1);
          e.last_buf   = e.eol || (in_buf == size);
          e.last_frame = e.eol && (l == h - 1);
          e.act        = buf_idx[0] ? 2'b10 : 2'b01;
          exp_q.push_back(e);
          if (e.last_buf) begin
            buf_idx++;
            in_buf = 0;
          end
        end
      end
    end
  endtask

  // Streams frames through the DUT with a ppfifo-like rdy emulation and checks every cycle.
  task automatic run_stream(input string name, input int w, input int h, input int size,
                            input int frames, input bit toggle);
    logic [1:0] rdy;
    logic [1:0] prev_act;
    int         drain_q[$];
    int         timer;
    int         cyc;
    int         exp_line;
    int         b;
    bit         exp_done;
    bit         exp_idle_next;
    exp_t       e;

    do_reset();
    build_model(w, h, size, frames);
    rdy            = 2'b11;
    prev_act       = 2'b00;
    timer          = 0;
    cyc            = 0;
    exp_line       = 0;
    exp_done       = 1'b0;
    exp_idle_next  = 1'b0;
    i_image_width  = w;
    i_image_height = h;
    i_wr_size      = 24'(size);
    i_enable       = 1'b1;

    while ((exp_q.size() > 0 || exp_done || exp_idle_next) && cyc < 4000) begin
      i_s_valid = toggle ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0);
      i_s_data  = 24'($urandom);
      i_wr_rdy  = rdy;
      @(negedge clk);
      compared++;
      if (o_frame_done !== exp_done) begin
        mismatched++;
        $display("[TB] FAIL %s frame_done cyc %0d: got %b want %b", name, cyc, o_frame_done, exp_done);
      end
      compared++;
      if (o_line_count !== 32'(exp_line)) begin
        mismatched++;
        $display("[TB] FAIL %s line_count cyc %0d: got %0d want %0d", name, cyc, o_line_count, exp_line);
      end
      if (exp_idle_next) begin
        compared++;
        if (o_wr_act !== 2'b00 || o_s_ready !== 1'b0) begin
          mismatched++;
          $display("[TB] FAIL %s release act/ready: got %b/%b want 00/0", name, o_wr_act, o_s_ready);
        end
      end
      exp_done      = 1'b0;
      exp_idle_next = 1'b0;
      if (o_wr_stb === 1'b1) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL %s extra strobe cyc %0d: got 1 want 0", name, cyc);
        end else begin
          e = exp_q.pop_front();
          compared++;
          if (o_wr_data !== {e.eol, i_s_data}) begin
            mismatched++;
            $display("[TB] FAIL %s wr_data: got %h want %h", name, o_wr_data, {e.eol, i_s_data});
          end
          compared++;
          if (o_wr_act !== e.act) begin
            mismatched++;
            $display("[TB] FAIL %s wr_act: got %b want %b", name, o_wr_act, e.act);
          end
          compared++;
          if (i_s_valid !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL %s strobe without valid: got stb 1 want 0", name);
          end
          if (e.eol) exp_line = e.last_frame ? 0 : exp_line + 1;
          exp_done      = e.last_frame;
          exp_idle_next = e.last_buf;
        end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (o_wr_act[i] && !prev_act[i]) rdy[i] = 1'b0;
        if (!o_wr_act[i] && prev_act[i]) drain_q.push_back(i);
      end
      prev_act = o_wr_act;
      if (drain_q.size() > 0) begin
        timer++;
        if (timer >= 3) begin
          b       = drain_q.pop_front();
          rdy[b]  = 1'b1;
          timer   = 0;
        end
      end
      cyc++;
    end
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL %s timeout: got %0d words left want 0", name, exp_q.size());
    end
    i_enable  = 1'b0;
    i_s_valid = 1'b0;
  endtask

  task automatic test_reset();
    i_image_width  = 4;
    i_image_height = 2;
    i_wr_size      = 24'd8;
    rst            = 1'b1;
    i_enable       = 1'b1;
    i_s_valid      = 1'b1;
    i_s_data       = 24'habcdef;
    i_wr_rdy       = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    compared++;
    if ({o_wr_act, o_wr_stb, o_s_ready, o_wr_data, o_line_count, o_frame_done, o_cfg_err} !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset outputs: got act %b stb %b rdy %b data %h line %0d done %b err %b want all 0",
               o_wr_act, o_wr_stb, o_s_ready, o_wr_data, o_line_count, o_frame_done, o_cfg_err);
    end
    do_reset();
  endtask

  task automatic test_basic();
    run_stream("w4h2", 4, 2, 8, 1, 1'b0);
  endtask

  task automatic test_split();
    run_stream("w10s4", 10, 1, 4, 1, 1'b0);
  endtask

  task automatic test_toggle();
    run_stream("toggle", 5, 2, 3, 1, 1'b1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      run_stream($sformatf("rand%0d", k), $urandom_range(1, 12), $urandom_range(1, 3),
                 $urandom_range(1, 8), 2, 1'b0);
    end
  endtask

  task automatic test_rdy_stall();
    do_reset();
    i_image_width  = 4;
    i_image_height = 1;
    i_wr_size      = 24'd8;
    i_enable       = 1'b1;
    i_s_valid      = 1'b1;
    i_wr_rdy       = 2'b00;
    repeat (20) begin
      @(negedge clk);
      compared++;
      if (o_s_ready !== 1'b0 || o_wr_stb !== 1'b0 || o_wr_act !== 2'b00) begin
        mismatched++;
        $display("[TB] FAIL stall: got rdy %b stb %b act %b want 0 0 00", o_s_ready, o_wr_stb, o_wr_act);
      end
      @(posedge clk);
      #1;
    end
    i_wr_rdy = 2'b10;
    @(negedge clk);
    compared++;
    if (o_wr_act !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL stall grab early: got act %b want 00", o_wr_act);
    end
    @(negedge clk);
    compared++;
    if (o_wr_act !== 2'b10) begin
      mismatched++;
      $display("[TB] FAIL stall grab: got act %b want 10", o_wr_act);
    end
  endtask

  task automatic test_reset_mid_fill();
    int writes;
    int cyc;
    do_reset();
    i_image_width  = 2;
    i_image_height = 4;
    i_wr_size      = 24'd8;
    i_enable       = 1'b1;
    i_s_valid      = 1'b1;
    i_wr_rdy       = 2'b11;
    writes         = 0;
    cyc            = 0;
    while (writes < 3 && cyc < 100) begin
      i_s_data = 24'($urandom);
      @(negedge clk);
      if (o_wr_stb === 1'b1) writes++;
      @(posedge clk);
      #1;
      cyc++;
    end
    compared++;
    if (writes != 3) begin
      mismatched++;
      $display("[TB] FAIL midfill writes: got %0d want 3", writes);
    end
    i_s_valid = 1'b0;
    @(negedge clk);
    compared++;
    if (o_line_count !== 32'd1 || o_wr_act !== 2'b01) begin
      mismatched++;
      $display("[TB] FAIL midfill pre-reset: got line %0d act %b want 1 01", o_line_count, o_wr_act);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    i_enable  = 1'b0;
    i_s_valid = 1'b1;
    @(negedge clk);
    compared++;
    if (o_wr_act !== 2'b00 || o_s_ready !== 1'b0 || o_line_count !== 32'd0 || o_wr_stb !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL midfill reset: got act %b rdy %b line %0d stb %b want 00 0 0 0",
               o_wr_act, o_s_ready, o_line_count, o_wr_stb);
    end
    repeat (4) begin
      @(negedge clk);
      compared++;
      if (o_wr_act !== 2'b00 || o_s_ready !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL midfill idle: got act %b rdy %b want 00 0", o_wr_act, o_s_ready);
      end
    end
  endtask

  task automatic test_cfg_err();
    logic [31:0] widths  [2];
    logic [31:0] heights [2];
    widths[0]  = 32'd0;
    heights[0] = 32'd3;
    widths[1]  = 32'd5;
    heights[1] = 32'd0;
    for (int c = 0; c < 2; c++) begin
      do_reset();
      i_image_width  = widths[c];
      i_image_height = heights[c];
      i_wr_size      = 24'd8;
      i_enable       = 1'b1;
      i_s_valid      = 1'b1;
      i_wr_rdy       = 2'b11;
      @(posedge clk);
      #1;
      repeat (6) begin
        @(negedge clk);
        compared++;
        if (o_cfg_err !== 1'b1 || o_wr_act !== 2'b00 || o_wr_stb !== 1'b0) begin
          mismatched++;
          $display("[TB] FAIL cfg_err case %0d: got err %b act %b stb %b want 1 00 0",
                   c, o_cfg_err, o_wr_act, o_wr_stb);
        end
      end
    end
    i_enable       = 1'b0;
    i_image_width  = 32'd5;
    i_image_height = 32'd3;
    @(posedge clk);
    @(negedge clk);
    compared++;
    if (o_cfg_err !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL cfg_err clear: got %b want 0", o_cfg_err);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_split();
    test_toggle();
    test_random();
    test_rdy_stall();
    test_reset_mid_fill();
    test_cfg_err();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
